// File: rtl/hwpe_stream_loopback_pkg.sv
// Shared types for the TCDM loopback streamer.
// Control/flag bundles for source, sink and FIFOs.
package hwpe_stream_loopback_pkg;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [31:0] line_stride;
    logic [15:0] line_length;
    logic [31:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  line_length_remainder;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef struct packed {
    logic empty;
    logic full;
  } flags_fifo_t;

  typedef enum logic {
    ENG_IDLE,
    ENG_BUSY
  } eng_state_e;

  // A zero line length behaves like a line of one word.
  function automatic logic line_wrap(
    input logic [15:0] col,
    input logic [15:0] len
  );
    return (len == 16'd0) || (col == len - 16'd1);
  endfunction

endpackage

// File: rtl/hwpe_loopback_fifo.sv
// Synchronous circular FIFO with occupancy count.
// Push on full is accepted only alongside a valid pop.
module hwpe_loopback_fifo
  import hwpe_stream_loopback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CW-1:0]         count_o,
  output flags_fifo_t           flags_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = pop_i && !w_empty;
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  assign data_o        = r_mem[r_rptr];
  assign count_o       = r_cnt;
  assign flags_o.empty = w_empty;
  assign flags_o.full  = w_full;

endmodule

// File: rtl/hwpe_stream_loopback.sv
// TCDM loopback: source reads words into a load FIFO,
// words move to a store FIFO, sink writes them back.
module hwpe_stream_loopback
  import hwpe_stream_loopback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NB_TCDM_PORTS = 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  output logic                  load_req_o,
  output logic [31:0]           load_add_o,
  output logic                  load_wen_o,
  output logic [3:0]            load_be_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  input  logic                  load_gnt_i,
  input  logic [DATA_WIDTH-1:0] load_r_data_i,
  input  logic                  load_r_valid_i,
  output logic                  store_req_o,
  output logic [31:0]           store_add_o,
  output logic                  store_wen_o,
  output logic [3:0]            store_be_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  input  logic                  store_gnt_i,
  input  ctrl_sourcesink_t      source_ctrl_i,
  input  ctrl_sourcesink_t      sink_ctrl_i,
  output flags_sourcesink_t     source_flags_o,
  output flags_sourcesink_t     sink_flags_o,
  output flags_fifo_t           load_fifo_flags_o,
  output flags_fifo_t           store_fifo_flags_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic w_rst;
  assign w_rst = rst_i || clear_i;

  // ---------------- source engine ----------------
  eng_state_e  r_src_state;
  eng_state_e  w_src_next;
  logic [31:0] r_src_size;
  logic [31:0] r_src_stride;
  logic [15:0] r_src_len;
  logic [31:0] r_src_line;
  logic [15:0] r_src_col;
  logic [31:0] r_src_issued;
  logic [31:0] r_src_recv;
  logic [CW-1:0] r_src_outst;
  logic          w_src_start;
  logic          w_src_fire;
  logic          w_src_push;
  logic          w_src_req;
  logic          w_src_done;
  logic [CW-1:0] w_load_cnt;
  logic [CW-1:0] w_load_free;

  assign w_src_start = (r_src_state == ENG_IDLE)
                    && source_ctrl_i.req_start;
  assign w_load_free = CW'(FIFO_DEPTH) - w_load_cnt;
  // Responses with nothing outstanding predate a reset.
  assign w_src_push  = load_r_valid_i && (r_src_outst != '0);
  assign w_src_fire  = w_src_req && load_gnt_i;

  always_ff @(posedge clk_i) begin
    if (w_rst) r_src_state <= ENG_IDLE;
    else       r_src_state <= w_src_next;
  end

  always_comb begin
    w_src_next = r_src_state;
    w_src_req  = 1'b0;
    w_src_done = 1'b0;
    case (r_src_state)
      ENG_IDLE: begin
        if (source_ctrl_i.req_start) w_src_next = ENG_BUSY;
      end
      ENG_BUSY: begin
        w_src_req  = (r_src_issued != r_src_size)
                  && (w_load_free > r_src_outst);
        w_src_done = (r_src_size == '0)
                  || (w_src_push
                      && r_src_recv == r_src_size - 32'd1);
        if (w_src_done) w_src_next = ENG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_src_size   <= '0;
      r_src_stride <= '0;
      r_src_len    <= '0;
      r_src_line   <= '0;
      r_src_col    <= '0;
      r_src_issued <= '0;
      r_src_recv   <= '0;
      r_src_outst  <= '0;
    end else begin
      if (w_src_start) begin
        r_src_size   <= source_ctrl_i.addressgen_ctrl.trans_size;
        r_src_stride <= source_ctrl_i.addressgen_ctrl.line_stride;
        r_src_len    <= source_ctrl_i.addressgen_ctrl.line_length;
        r_src_line   <= source_ctrl_i.addressgen_ctrl.base_addr;
        r_src_col    <= '0;
        r_src_issued <= '0;
        r_src_recv   <= '0;
      end else begin
        if (w_src_fire) begin
          r_src_issued <= r_src_issued + 32'd1;
          if (line_wrap(r_src_col, r_src_len)) begin
            r_src_col  <= '0;
            r_src_line <= r_src_line + r_src_stride;
          end else begin
            r_src_col  <= r_src_col + 16'd1;
          end
        end
        if (w_src_push) r_src_recv <= r_src_recv + 32'd1;
      end
      if (w_src_fire && !w_src_push)
        r_src_outst <= r_src_outst + CW'(1);
      else if (!w_src_fire && w_src_push)
        r_src_outst <= r_src_outst - CW'(1);
    end
  end

  assign load_req_o  = w_src_req;
  assign load_add_o  = w_src_req
                     ? r_src_line + 32'({r_src_col, 2'b00})
                     : '0;
  assign load_wen_o  = w_src_req;
  assign load_be_o   = {4{w_src_req}};
  assign load_data_o = '0;

  assign source_flags_o.ready_start = (r_src_state == ENG_IDLE);
  assign source_flags_o.done        = w_src_done;

  // ---------------- FIFOs ----------------
  logic [DATA_WIDTH-1:0] w_load_head;
  logic [DATA_WIDTH-1:0] w_store_head;
  logic [CW-1:0]         w_store_cnt;
  logic                  w_move;
  logic                  w_snk_fire;

  assign w_move = !load_fifo_flags_o.empty
               && !store_fifo_flags_o.full;

  hwpe_loopback_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) i_load_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_src_push),
    .data_i  (load_r_data_i),
    .pop_i   (w_move),
    .data_o  (w_load_head),
    .count_o (w_load_cnt),
    .flags_o (load_fifo_flags_o)
  );

  hwpe_loopback_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) i_store_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_move),
    .data_i  (w_load_head),
    .pop_i   (w_snk_fire),
    .data_o  (w_store_head),
    .count_o (w_store_cnt),
    .flags_o (store_fifo_flags_o)
  );

  // ---------------- sink engine ----------------
  eng_state_e  r_snk_state;
  eng_state_e  w_snk_next;
  logic [31:0] r_snk_size;
  logic [31:0] r_snk_stride;
  logic [15:0] r_snk_len;
  logic [31:0] r_snk_line;
  logic [15:0] r_snk_col;
  logic [31:0] r_snk_written;
  logic        w_snk_start;
  logic        w_snk_req;
  logic        w_snk_done;

  assign w_snk_start = (r_snk_state == ENG_IDLE)
                    && sink_ctrl_i.req_start;
  assign w_snk_fire  = w_snk_req && store_gnt_i;

  always_ff @(posedge clk_i) begin
    if (w_rst) r_snk_state <= ENG_IDLE;
    else       r_snk_state <= w_snk_next;
  end

  always_comb begin
    w_snk_next = r_snk_state;
    w_snk_req  = 1'b0;
    w_snk_done = 1'b0;
    case (r_snk_state)
      ENG_IDLE: begin
        if (sink_ctrl_i.req_start) w_snk_next = ENG_BUSY;
      end
      ENG_BUSY: begin
        w_snk_req  = (r_snk_written != r_snk_size)
                  && !store_fifo_flags_o.empty;
        w_snk_done = (r_snk_size == '0)
                  || (store_gnt_i && w_snk_req
                      && r_snk_written == r_snk_size - 32'd1);
        if (w_snk_done) w_snk_next = ENG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_snk_size    <= '0;
      r_snk_stride  <= '0;
      r_snk_len     <= '0;
      r_snk_line    <= '0;
      r_snk_col     <= '0;
      r_snk_written <= '0;
    end else if (w_snk_start) begin
      r_snk_size    <= sink_ctrl_i.addressgen_ctrl.trans_size;
      r_snk_stride  <= sink_ctrl_i.addressgen_ctrl.line_stride;
      r_snk_len     <= sink_ctrl_i.addressgen_ctrl.line_length;
      r_snk_line    <= sink_ctrl_i.addressgen_ctrl.base_addr;
      r_snk_col     <= '0;
      r_snk_written <= '0;
    end else if (w_snk_fire) begin
      r_snk_written <= r_snk_written + 32'd1;
      if (line_wrap(r_snk_col, r_snk_len)) begin
        r_snk_col  <= '0;
        r_snk_line <= r_snk_line + r_snk_stride;
      end else begin
        r_snk_col  <= r_snk_col + 16'd1;
      end
    end
  end

  assign store_req_o  = w_snk_req;
  assign store_add_o  = w_snk_req
                      ? r_snk_line + 32'({r_snk_col, 2'b00})
                      : '0;
  assign store_wen_o  = 1'b0;
  assign store_be_o   = {4{w_snk_req}};
  assign store_data_o = w_snk_req ? w_store_head : '0;

  assign sink_flags_o.ready_start = (r_snk_state == ENG_IDLE);
  assign sink_flags_o.done        = w_snk_done;

  // Multi-dimensional addressing fields have no effect here.
  logic w_unused;
  assign w_unused = ^{
    source_ctrl_i.addressgen_ctrl.feat_stride,
    source_ctrl_i.addressgen_ctrl.feat_length,
    source_ctrl_i.addressgen_ctrl.feat_roll,
    source_ctrl_i.addressgen_ctrl.loop_outer,
    source_ctrl_i.addressgen_ctrl.realign_type,
    source_ctrl_i.addressgen_ctrl.line_length_remainder,
    sink_ctrl_i.addressgen_ctrl.feat_stride,
    sink_ctrl_i.addressgen_ctrl.feat_length,
    sink_ctrl_i.addressgen_ctrl.feat_roll,
    sink_ctrl_i.addressgen_ctrl.loop_outer,
    sink_ctrl_i.addressgen_ctrl.realign_type,
    sink_ctrl_i.addressgen_ctrl.line_length_remainder,
    w_store_cnt,
    1'(NB_TCDM_PORTS)
  };

endmodule

// File: tb/tb_hwpe_stream_loopback.sv
// Randomized scoreboard bench for hwpe_stream_loopback.
// Expected traffic comes from the address formula and a memory image.
module tb_hwpe_stream_loopback;
  import hwpe_stream_loopback_pkg::*;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              load_req_o, load_wen_o;
  logic [31:0]       load_add_o, load_data_o;
  logic [3:0]        load_be_o;
  logic              load_gnt_i, load_r_valid_i;
  logic [31:0]       load_r_data_i;
  logic              store_req_o, store_wen_o, store_gnt_i;
  logic [31:0]       store_add_o, store_data_o;
  logic [3:0]        store_be_o;
  ctrl_sourcesink_t  source_ctrl_i, sink_ctrl_i;
  flags_sourcesink_t source_flags_o, sink_flags_o;
  flags_fifo_t       load_fifo_flags_o, store_fifo_flags_o;

  always #5 clk = ~clk;

  hwpe_stream_loopback #(
    .DATA_WIDTH(32), .NB_TCDM_PORTS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .load_req_o(load_req_o), .load_add_o(load_add_o),
    .load_wen_o(load_wen_o), .load_be_o(load_be_o),
    .load_data_o(load_data_o), .load_gnt_i(load_gnt_i),
    .load_r_data_i(load_r_data_i),
    .load_r_valid_i(load_r_valid_i),
    .store_req_o(store_req_o), .store_add_o(store_add_o),
    .store_wen_o(store_wen_o), .store_be_o(store_be_o),
    .store_data_o(store_data_o), .store_gnt_i(store_gnt_i),
    .source_ctrl_i(source_ctrl_i), .sink_ctrl_i(sink_ctrl_i),
    .source_flags_o(source_flags_o), .sink_flags_o(sink_flags_o),
    .load_fifo_flags_o(load_fifo_flags_o),
    .store_fifo_flags_o(store_fifo_flags_o)
  );

  logic [31:0] mem [256];
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned load_prob = 100;
  int unsigned store_prob = 100;
  int          src_done_cnt = 0;
  int          snk_done_cnt = 0;
  logic [31:0] exp_load_q [$];
  logic [63:0] exp_store_q [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] agen(input ctrl_addressgen_t c,
                                       input int j);
    int ll;
    ll = (c.line_length == 16'd0) ? 1 : int'(c.line_length);
    return c.base_addr + 32'(j / ll) * c.line_stride
         + 32'(j % ll) * 32'd4;
  endfunction

  function automatic ctrl_addressgen_t mk(input logic [31:0] base,
                                          input logic [31:0] size,
                                          input logic [31:0] stride,
                                          input logic [15:0] len);
    ctrl_addressgen_t c;
    c.base_addr             = base;
    c.trans_size            = size;
    c.line_stride           = stride;
    c.line_length           = len;
    c.feat_stride           = $urandom;
    c.feat_length           = 16'($urandom);
    c.feat_roll             = 16'($urandom);
    c.loop_outer            = 1'($urandom);
    c.realign_type          = 1'($urandom);
    c.line_length_remainder = 8'($urandom);
    return c;
  endfunction

  task automatic plan(input ctrl_addressgen_t s,
                      input ctrl_addressgen_t d);
    logic [31:0] la;
    exp_load_q.delete();
    exp_store_q.delete();
    for (int j = 0; j < int'(s.trans_size); j++) begin
      la = agen(s, j);
      exp_load_q.push_back(la);
      exp_store_q.push_back({agen(d, j), mem[la[9:2]]});
    end
  endtask

  task automatic start(input ctrl_addressgen_t s,
                       input ctrl_addressgen_t d);
    plan(s, d);
    src_done_cnt = 0;
    snk_done_cnt = 0;
    @(negedge clk);
    source_ctrl_i = '{req_start: 1'b1, addressgen_ctrl: s};
    sink_ctrl_i   = '{req_start: 1'b1, addressgen_ctrl: d};
    @(negedge clk);
    source_ctrl_i.req_start = 1'b0;
    sink_ctrl_i.req_start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((src_done_cnt == 0 || snk_done_cnt == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    check({name, " src done pulses"}, src_done_cnt, 1);
    check({name, " snk done pulses"}, snk_done_cnt, 1);
    check({name, " loads left"}, exp_load_q.size(), 0);
    check({name, " stores left"}, exp_store_q.size(), 0);
  endtask

  task automatic idle_flags(input string name);
    check({name, " src flags"}, 32'(source_flags_o), 32'h2);
    check({name, " snk flags"}, 32'(sink_flags_o), 32'h2);
    check({name, " reqs"}, {30'b0, load_req_o, store_req_o}, 0);
    check({name, " addrs"}, load_add_o | store_add_o | store_data_o, 0);
    check({name, " lfifo"}, 32'(load_fifo_flags_o), 32'h2);
    check({name, " sfifo"}, 32'(store_fifo_flags_o), 32'h2);
  endtask

  // Memory responder plus request stability checks.
  initial begin
    logic        pend, lhold, shold;
    logic [31:0] pend_addr, lhold_addr, shold_addr, shold_data;
    logic [31:0] e;
    pend = 1'b0; lhold = 1'b0; shold = 1'b0;
    pend_addr = '0; lhold_addr = '0;
    shold_addr = '0; shold_data = '0;
    load_gnt_i = 1'b0; store_gnt_i = 1'b0;
    load_r_valid_i = 1'b0; load_r_data_i = '0;
    forever begin
      @(negedge clk);
      load_r_valid_i = pend;
      load_r_data_i  = pend ? mem[pend_addr[9:2]] : $urandom;
      load_gnt_i     = ($urandom_range(99) < load_prob);
      store_gnt_i    = ($urandom_range(99) < store_prob);
      #2;
      if (!rst_i) begin
        if (lhold) begin
          check("load hold req", 32'(load_req_o), 1);
          check("load hold addr", load_add_o, lhold_addr);
        end
        if (shold) begin
          check("store hold req", 32'(store_req_o), 1);
          check("store hold addr", store_add_o, shold_addr);
          check("store hold data", store_data_o, shold_data);
        end
        if (load_req_o && load_gnt_i) begin
          check("load req expected", 32'(exp_load_q.size() != 0), 1);
          if (exp_load_q.size() != 0) begin
            e = exp_load_q.pop_front();
            check("load addr", load_add_o, e);
            check("load wen/be", {27'b0, load_wen_o, load_be_o}, 32'h1F);
          end
        end
      end
      pend       = load_req_o && load_gnt_i;
      pend_addr  = load_add_o;
      lhold      = load_req_o && !load_gnt_i;
      lhold_addr = load_add_o;
      shold      = store_req_o && !store_gnt_i;
      shold_addr = store_add_o;
      shold_data = store_data_o;
    end
  end

  // Store-side scoreboard monitor.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i) begin
        if (source_flags_o.done) src_done_cnt++;
        if (sink_flags_o.done)   snk_done_cnt++;
        if (store_req_o && store_gnt_i) begin
          check("store expected", 32'(exp_store_q.size() != 0), 1);
          if (exp_store_q.size() != 0) begin
            e = exp_store_q.pop_front();
            check("store addr", store_add_o, e[63:32]);
            check("store data", store_data_o, e[31:0]);
            check("store wen/be", {27'b0, store_wen_o, store_be_o}, 32'hF);
          end
        end
      end
    end
  end

  task automatic abort(input string name, input logic use_clear);
    start(mk(32'd0, 32'd10, 32'd4, 16'd1),
          mk(32'd512, 32'd10, 32'd4, 16'd1));
    repeat (3) @(negedge clk);
    if (use_clear) clear_i = 1'b1;
    else           rst_i   = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    clear_i = 1'b0;
    #2;
    idle_flags(name);
    @(negedge clk);
    #2;
    check({name, " stale read dropped"}, 32'(load_fifo_flags_o), 32'h2);
    check({name, " no done"}, src_done_cnt + snk_done_cnt, 0);
  endtask

  initial begin
    ctrl_addressgen_t s, d;
    logic [31:0] sz;
    source_ctrl_i = '0;
    sink_ctrl_i   = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001;
    mem[3] = 32'hBBBB_0002;
    mem[6] = 32'hCCCC_0003;
    repeat (3) @(negedge clk);
    #2;
    idle_flags("reset");
    @(negedge clk);
    rst_i = 1'b0;

    s = mk(32'd0, 32'd3, 32'd12, 16'd1);
    start(s, s);
    wait_done("basic", 200);

    load_prob = 90;
    start(s, s);
    wait_done("load stall", 400);

    for (int it = 0; it < 6; it++) begin
      sz = $urandom_range(1, 16);
      s = mk(32'($urandom_range(0, 31)) * 4, sz,
             32'($urandom_range(0, 8)) * 4, 16'($urandom_range(1, 4)));
      d = mk(32'($urandom_range(32, 63)) * 4, sz,
             32'($urandom_range(0, 8)) * 4, 16'($urandom_range(1, 4)));
      load_prob  = $urandom_range(50, 100);
      store_prob = $urandom_range(50, 100);
      start(s, d);
      wait_done("random", 1000);
    end

    load_prob = 100;
    store_prob = 0;
    s = mk(32'd0, 32'd12, 32'd4, 16'd1);
    start(s, mk(32'd256, 32'd12, 32'd4, 16'd1));
    repeat (40) @(negedge clk);
    #2;
    check("backpressure sfifo full", 32'(store_fifo_flags_o.full), 1);
    check("backpressure lfifo full", 32'(load_fifo_flags_o.full), 1);
    check("backpressure load_req", 32'(load_req_o), 0);
    store_prob = 100;
    wait_done("backpressure", 400);

    s = mk(32'd64, 32'd0, 32'd4, 16'd1);
    start(s, s);
    #2;
    check("zero src done", 32'(source_flags_o.done), 1);
    check("zero snk done", 32'(sink_flags_o.done), 1);
    check("zero reqs", {30'b0, load_req_o, store_req_o}, 0);
    @(negedge clk);
    #2;
    check("zero after src", 32'(source_flags_o), 32'h2);
    check("zero after snk", 32'(sink_flags_o), 32'h2);
    wait_done("zero", 20);

    store_prob = 60;
    s = mk(32'd16, 32'd8, 32'd20, 16'd2);
    d = mk(32'd300, 32'd8, 32'd8, 16'd3);
    start(s, d);
    @(negedge clk);
    source_ctrl_i = '{req_start: 1'b1,
                      addressgen_ctrl: mk(32'd800, 32'd2, 32'd4, 16'd1)};
    sink_ctrl_i   = '{req_start: 1'b1,
                      addressgen_ctrl: mk(32'd900, 32'd2, 32'd4, 16'd1)};
    #2;
    check("busy src ready", 32'(source_flags_o.ready_start), 0);
    check("busy snk ready", 32'(sink_flags_o.ready_start), 0);
    @(negedge clk);
    source_ctrl_i.req_start = 1'b0;
    sink_ctrl_i.req_start   = 1'b0;
    wait_done("ignored start", 400);

    store_prob = 100;
    abort("reset abort", 1'b0);
    abort("clear abort", 1'b1);

    s = mk(32'd0, 32'd3, 32'd12, 16'd1);
    start(s, s);
    wait_done("recovery", 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
